up_ack_combiner: RTL and testbench

UP_ACK_COMBINER -- requirements
Module: up_ack_combiner

---
 rtl/up_ack_combiner.sv | 179 +++++++++++++++++
 tb/tb_up_ack_combiner.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/up_ack_combiner.sv
// Broadcasts up-bus requests to NUM_CORES sub-cores and merges their acks into one registered response.
// Optional forced acknowledge on a stalled access is built when UP_ACK_TIMEOUT_EN is defined.
module up_ack_combiner #(
  parameter int NUM_CORES      = 3,
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic                      up_clk,
  input  logic                      up_rstn,
  input  logic                      up_wreq,
  input  logic [13:0]               up_waddr,
  input  logic [31:0]               up_wdata,
  input  logic                      up_rreq,
  input  logic [13:0]               up_raddr,
  output logic                      up_wack,
  output logic                      up_rack,
  output logic [31:0]               up_rdata,
  output logic                      up_wreq_c,
  output logic [13:0]               up_waddr_c,
  output logic [31:0]               up_wdata_c,
  output logic                      up_rreq_c,
  output logic [13:0]               up_raddr_c,
  input  logic [NUM_CORES-1:0]      up_wack_c,
  input  logic [NUM_CORES-1:0]      up_rack_c,
  input  logic [32*NUM_CORES-1:0]   up_rdata_c,
  input  logic                      up_status_clr,
  output logic                      up_timeout,
  output logic                      up_multi_ack,
  output logic [15:0]               up_timeout_count
);

  if (NUM_CORES < 1 || NUM_CORES > 8) begin : g_bad_cores
    $error("up_ack_combiner: NUM_CORES must be within 1..8");
  end
  if (TIMEOUT_CYCLES < 4 || TIMEOUT_CYCLES > 1024) begin : g_bad_timeout
    $error("up_ack_combiner: TIMEOUT_CYCLES must be within 4..1024");
  end

  typedef enum logic {W_IDLE, W_WAIT} wstate_t;
  typedef enum logic {R_IDLE, R_WAIT} rstate_t;

  wstate_t     wstate, wstate_nxt;
  rstate_t     rstate, rstate_nxt;
  logic        wack_nxt, rack_nxt;
  logic [31:0] rdata_nxt, rdata_or;
  logic        w_ack_any, r_ack_any;
  logic        w_to, r_to;
  logic        multi_set;

  function automatic logic multi_hot(input logic [NUM_CORES-1:0] v);
    return (v & (v - NUM_CORES'(1))) != '0;
  endfunction

  assign w_ack_any  = |up_wack_c;
  assign r_ack_any  = |up_rack_c;
  assign up_waddr_c = up_waddr;
  assign up_wdata_c = up_wdata;
  assign up_raddr_c = up_raddr;

  always_comb begin
    rdata_or = '0;
    for (int unsigned k = 0; k < NUM_CORES; k++) begin
      if (up_rack_c[k]) rdata_or |= up_rdata_c[32*k +: 32];
    end
  end

`ifdef UP_ACK_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);

  logic [CW-1:0] w_cnt, r_cnt;
  logic [1:0]    to_hits;
  logic [16:0]   count_sum;
  logic [15:0]   count_nxt;

  // Counters rest at zero while idle, so every WAIT entry starts from 0.
  always_ff @(posedge up_clk) begin
    if (!up_rstn) begin
      w_cnt <= '0;
      r_cnt <= '0;
    end else begin
      if (wstate == W_IDLE)  w_cnt <= '0;
      else if (!w_ack_any)   w_cnt <= w_cnt + CW'(1);
      if (rstate == R_IDLE)  r_cnt <= '0;
      else if (!r_ack_any)   r_cnt <= r_cnt + CW'(1);
    end
  end

  assign w_to = (wstate == W_WAIT) && !w_ack_any && (w_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign r_to = (rstate == R_WAIT) && !r_ack_any && (r_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    to_hits   = {1'b0, w_to} + {1'b0, r_to};
    count_sum = {1'b0, (up_status_clr ? 16'h0000 : up_timeout_count)} + 17'(to_hits);
    count_nxt = count_sum[16] ? 16'hFFFF : count_sum[15:0];
  end

  always_ff @(posedge up_clk) begin
    if (!up_rstn) begin
      up_timeout       <= 1'b0;
      up_timeout_count <= '0;
    end else begin
      if (w_to || r_to)       up_timeout <= 1'b1;
      else if (up_status_clr) up_timeout <= 1'b0;
      up_timeout_count <= count_nxt;
    end
  end
`else
  assign w_to             = 1'b0;
  assign r_to             = 1'b0;
  assign up_timeout       = 1'b0;
  assign up_timeout_count = '0;
`endif

  always_comb begin
    wstate_nxt = wstate;
    wack_nxt   = 1'b0;
    up_wreq_c  = 1'b0;
    case (wstate)
      W_IDLE: begin
        up_wreq_c = up_wreq;
        if (up_wreq) wstate_nxt = W_WAIT;
      end
      W_WAIT: begin
        if (w_ack_any || w_to) begin
          wack_nxt   = 1'b1;
          wstate_nxt = W_IDLE;
        end
      end
      default: wstate_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    rstate_nxt = rstate;
    rack_nxt   = 1'b0;
    rdata_nxt  = '0;
    up_rreq_c  = 1'b0;
    case (rstate)
      R_IDLE: begin
        up_rreq_c = up_rreq;
        if (up_rreq) rstate_nxt = R_WAIT;
      end
      R_WAIT: begin
        if (r_ack_any) begin
          rack_nxt   = 1'b1;
          rdata_nxt  = rdata_or;
          rstate_nxt = R_IDLE;
        end else if (r_to) begin
          rack_nxt   = 1'b1;
          rdata_nxt  = 32'hDEADDEAD;
          rstate_nxt = R_IDLE;
        end
      end
      default: rstate_nxt = R_IDLE;
    endcase
  end

  assign multi_set = ((wstate == W_WAIT) && multi_hot(up_wack_c)) ||
                     ((rstate == R_WAIT) && multi_hot(up_rack_c));

  always_ff @(posedge up_clk) begin
    if (!up_rstn) begin
      wstate       <= W_IDLE;
      rstate       <= R_IDLE;
      up_wack      <= 1'b0;
      up_rack      <= 1'b0;
      up_rdata     <= '0;
      up_multi_ack <= 1'b0;
    end else begin
      wstate   <= wstate_nxt;
      rstate   <= rstate_nxt;
      up_wack  <= wack_nxt;
      up_rack  <= rack_nxt;
      up_rdata <= rdata_nxt;
      if (multi_set)          up_multi_ack <= 1'b1;
      else if (up_status_clr) up_multi_ack <= 1'b0;
    end
  end

endmodule

// File: tb/tb_up_ack_combiner.sv
// Directed bench for up_ack_combiner: expected responses are queued when a request is
// driven and matched, cycle-exact, against each up_wack/up_rack pulse the DUT produces.
module tb_up_ack_combiner;

  localparam int NC = 3;

  logic              up_clk = 1'b0;
  logic              up_rstn;
  logic              up_wreq, up_rreq;
  logic [13:0]       up_waddr, up_raddr;
  logic [31:0]       up_wdata;
  logic              up_wack, up_rack;
  logic [31:0]       up_rdata;
  logic              up_wreq_c, up_rreq_c;
  logic [13:0]       up_waddr_c, up_raddr_c;
  logic [31:0]       up_wdata_c;
  logic [NC-1:0]     up_wack_c, up_rack_c;
  logic [32*NC-1:0]  up_rdata_c;
  logic              up_status_clr;
  logic              up_timeout, up_multi_ack;
  logic [15:0]       up_timeout_count;

  always #5 up_clk = ~up_clk;

  up_ack_combiner #(.NUM_CORES(NC), .TIMEOUT_CYCLES(8)) dut (
    .up_clk(up_clk), .up_rstn(up_rstn),
    .up_wreq(up_wreq), .up_waddr(up_waddr), .up_wdata(up_wdata),
    .up_rreq(up_rreq), .up_raddr(up_raddr),
    .up_wack(up_wack), .up_rack(up_rack), .up_rdata(up_rdata),
    .up_wreq_c(up_wreq_c), .up_waddr_c(up_waddr_c), .up_wdata_c(up_wdata_c),
    .up_rreq_c(up_rreq_c), .up_raddr_c(up_raddr_c),
    .up_wack_c(up_wack_c), .up_rack_c(up_rack_c), .up_rdata_c(up_rdata_c),
    .up_status_clr(up_status_clr), .up_timeout(up_timeout),
    .up_multi_ack(up_multi_ack), .up_timeout_count(up_timeout_count)
  );

  typedef struct {
    int          cyc;
    logic        wack;
    logic        rack;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   cyc     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(posedge up_clk);
    #1;
    cyc++;
    if (up_rack !== 1'b1) check("rdata_zero_when_idle", up_rdata, 32'h0);
    if (up_wack === 1'b1 || up_rack === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_ack", {30'b0, up_wack, up_rack}, 32'h0);
      end else begin
        e = sb.pop_front();
        check("ack_cycle", cyc, e.cyc);
        check("wack", {31'b0, up_wack}, {31'b0, e.wack});
        check("rack", {31'b0, up_rack}, {31'b0, e.rack});
        if (e.rack) check("rdata", up_rdata, e.rdata);
      end
    end
  endtask

  task automatic expect_empty(input string tag);
    check(tag, sb.size(), 32'h0);
    sb.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wack"},  {31'b0, up_wack}, 32'h0);
    check({tag, "_rack"},  {31'b0, up_rack}, 32'h0);
    check({tag, "_rdata"}, up_rdata, 32'h0);
    check({tag, "_timeout"}, {31'b0, up_timeout}, 32'h0);
    check({tag, "_multi"}, {31'b0, up_multi_ack}, 32'h0);
    check({tag, "_tcount"}, {16'h0, up_timeout_count}, 32'h0);
  endtask

  initial begin
    up_rstn = 1'b0; up_wreq = 1'b0; up_rreq = 1'b0;
    up_waddr = '0; up_raddr = '0; up_wdata = '0;
    up_wack_c = '0; up_rack_c = '0; up_rdata_c = '0; up_status_clr = 1'b0;

    // Reset state
    tick(); tick();
    check_all_zero("reset");
    up_rstn = 1'b1;
    tick();

    // Read to core 1 acking one cycle after the request
    up_rreq = 1'b1; up_raddr = 14'h0123;
    #1;
    check("rreq_c_idle", {31'b0, up_rreq_c}, 32'h1);
    check("raddr_c", {18'h0, up_raddr_c}, 32'h0123);
    sb.push_back('{cyc + 2, 1'b0, 1'b1, 32'h00A55A00});
    tick();
    up_rreq = 1'b0;
    up_rack_c = 3'b010;
    up_rdata_c = {32'h11111111, 32'h00A55A00, 32'h22222222};
    tick();
    up_rack_c = '0;
    tick();
    check("rack_single_pulse", {31'b0, up_rack}, 32'h0);
    expect_empty("sb_read_core1");
    check("multi_after_single", {31'b0, up_multi_ack}, 32'h0);

    // Write with cores 0 and 2 acking together
    up_wreq = 1'b1; up_waddr = 14'h3ABC; up_wdata = 32'h12345678;
    #1;
    check("wreq_c_idle", {31'b0, up_wreq_c}, 32'h1);
    check("wdata_c", up_wdata_c, 32'h12345678);
    check("waddr_c", {18'h0, up_waddr_c}, 32'h3ABC);
    sb.push_back('{cyc + 2, 1'b1, 1'b0, 32'h0});
    tick();
    up_wreq = 1'b0;
    up_wack_c = 3'b101;
    tick();
    up_wack_c = '0;
    check("multi_set", {31'b0, up_multi_ack}, 32'h1);
    tick(); tick();
    check("multi_sticky", {31'b0, up_multi_ack}, 32'h1);
    up_status_clr = 1'b1;
    tick();
    up_status_clr = 1'b0;
    check("multi_cleared", {31'b0, up_multi_ack}, 32'h0);
    expect_empty("sb_write_multi");

    // Second write while waiting is dropped
    up_wreq = 1'b1; up_wdata = 32'hAAAA5555;
    sb.push_back('{cyc + 3, 1'b1, 1'b0, 32'h0});
    tick();
    #1;
    check("wreq_c_blocked", {31'b0, up_wreq_c}, 32'h0);
    tick();
    up_wreq = 1'b0;
    up_wack_c = 3'b001;
    tick();
    up_wack_c = '0;
    tick(); tick(); tick();
    expect_empty("sb_dropped_write");

    // Concurrent read and write acked in the same cycle
    up_wreq = 1'b1; up_rreq = 1'b1;
    sb.push_back('{cyc + 2, 1'b1, 1'b1, 32'hCAFEF00D});
    tick();
    up_wreq = 1'b0; up_rreq = 1'b0;
    up_wack_c = 3'b100; up_rack_c = 3'b100;
    up_rdata_c = {32'hCAFEF00D, 32'hFFFFFFFF, 32'hFFFFFFFF};
    tick();
    up_wack_c = '0; up_rack_c = '0;
    tick();
    expect_empty("sb_concurrent");

    // Multi-core read ORs slices; set wins over a same-cycle clear
    up_rreq = 1'b1;
    sb.push_back('{cyc + 2, 1'b0, 1'b1, 32'h0FF00FF1});
    tick();
    up_rreq = 1'b0;
    up_rack_c = 3'b011;
    up_rdata_c = {32'hFFFFFFFF, 32'h0F000F00, 32'h00F000F1};
    up_status_clr = 1'b1;
    tick();
    up_status_clr = 1'b0;
    up_rack_c = '0;
    check("multi_set_wins", {31'b0, up_multi_ack}, 32'h1);
    up_status_clr = 1'b1;
    tick();
    up_status_clr = 1'b0;
    check("multi_clear2", {31'b0, up_multi_ack}, 32'h0);
    expect_empty("sb_or_read");

    // Stray acks in idle, including one alongside a new request
    up_rack_c = 3'b010; up_wack_c = 3'b001;
    up_rdata_c = {32'h0, 32'h5A5A0001, 32'h0};
    tick(); tick();
    up_rreq = 1'b1;
    sb.push_back('{cyc + 3, 1'b0, 1'b1, 32'h5A5A0001});
    tick();
    up_rreq = 1'b0; up_rack_c = '0; up_wack_c = '0;
    tick();
    up_rack_c = 3'b010;
    tick();
    up_rack_c = '0;
    tick();
    expect_empty("sb_stray");
    check("multi_stray", {31'b0, up_multi_ack}, 32'h0);

`ifdef UP_ACK_TIMEOUT_EN
    // Forced acknowledge after TIMEOUT_CYCLES of silence
    up_rreq = 1'b1;
    sb.push_back('{cyc + 9, 1'b0, 1'b1, 32'hDEADDEAD});
    tick();
    up_rreq = 1'b0;
    repeat (8) tick();
    check("timeout_flag", {31'b0, up_timeout}, 32'h1);
    check("timeout_count1", {16'h0, up_timeout_count}, 32'h1);
    tick();
    up_wreq = 1'b1;
    sb.push_back('{cyc + 9, 1'b1, 1'b0, 32'h0});
    tick();
    up_wreq = 1'b0;
    repeat (8) tick();
    check("timeout_count2", {16'h0, up_timeout_count}, 32'h2);
    expect_empty("sb_timeout");
    up_status_clr = 1'b1;
    tick();
    up_status_clr = 1'b0;
    check("timeout_cleared", {31'b0, up_timeout}, 32'h0);
    check("tcount_cleared", {16'h0, up_timeout_count}, 32'h0);
`else
    // Without the timeout feature a silent access waits indefinitely
    up_rreq = 1'b1;
    tick();
    up_rreq = 1'b0;
    repeat (20) tick();
    check("no_timeout_flag", {31'b0, up_timeout}, 32'h0);
    check("no_timeout_count", {16'h0, up_timeout_count}, 32'h0);
    up_rreq = 1'b1;
    #1;
    check("rreq_c_still_wait", {31'b0, up_rreq_c}, 32'h0);
    up_rreq = 1'b0;
    up_rstn = 1'b0;
    tick();
    up_rstn = 1'b1;
    tick();
    expect_empty("sb_no_timeout");
`endif

    // Reset mid-read, then a late core ack is stray
    up_rreq = 1'b1;
    tick();
    up_rreq = 1'b0;
    tick();
    up_rstn = 1'b0;
    tick();
    up_rstn = 1'b1;
    tick();
    tick();
    up_rack_c = 3'b010;
    up_rdata_c = {32'h0, 32'h77777777, 32'h0};
    tick();
    up_rack_c = '0;
    tick();
    check_all_zero("after_reset_abort");
    expect_empty("sb_reset_abort");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
